// File: rtl/rv_exec_stage_pkg.sv
// Shared RV32I definitions for the execute stage and the fetch/decode stage:
// opcode and funct3 constants, the EBREAK encoding and the stage FSM states.
package rv_exec_stage_pkg;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_WAIT_INSTR = 2'd0,
    S_READ_REGS  = 2'd1,
    S_EXECUTE    = 2'd2,
    S_HALT       = 2'd3
  } exec_state_e;

endpackage

// File: rtl/rv_exec_stage_regfile.sv
// rv_regfile: 32 x 32-bit register file, two synchronous read ports and one
// write port. x0 reads as zero and writes to it are dropped.
// Ports: clk; raddr1_i/raddr2_i -> rdata1_o/rdata2_o (one cycle later);
//        we_i, waddr_i, wdata_i write port.
module rv_regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] mem_q [32];
  logic [31:0] rd1_q, rd2_q;
  logic        zero1_q, zero2_q;

  // No reset on the array or read registers so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != 5'd0)) mem_q[waddr_i] <= wdata_i;
    rd1_q   <= mem_q[raddr1_i];
    rd2_q   <= mem_q[raddr2_i];
    zero1_q <= (raddr1_i == 5'd0);
    zero2_q <= (raddr2_i == 5'd0);
  end

  // x0 is masked at the output since the RAM word 0 is never initialised.
  assign rdata1_o = zero1_q ? 32'd0 : rd1_q;
  assign rdata2_o = zero2_q ? 32'd0 : rd2_q;

endmodule

// File: rtl/rv_exec_stage.sv
// rv_exec_stage: execute/write-back stage of the RV32I core. Takes one
// instruction per valid/ready handshake, reads rs1/rs2, runs ALUreg/ALUimm
// operations, writes rd, and halts on EBREAK.
// Ports: clk, resetn (sync, active-low); instr_valid/instr/instr_ready input
//        handshake; wb_valid/wb_rd/wb_data write-back report; unsupported
//        pulse for opcodes not executed here; halted after EBREAK.
module rv_exec_stage
  import rv_exec_stage_pkg::*;
#(
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        unsupported,
  output logic        halted
);

  exec_state_e state_q;
  logic [31:0] instr_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        halted_q;

  logic [31:0] rs1, rs2, op_b, alu_res;
  logic [4:0]  shamt;
  logic        is_alureg, is_aluimm, is_alu, is_ebreak, in_exec;

  rv_regfile u_regfile (
    .clk      (clk),
    .raddr1_i (instr_q[19:15]),
    .raddr2_i (instr_q[24:20]),
    .rdata1_o (rs1),
    .rdata2_o (rs2),
    .we_i     (wb_valid),
    .waddr_i  (instr_q[11:7]),
    .wdata_i  (alu_res)
  );

  assign is_alureg = (instr_q[6:0] == OP_ALUREG);
  assign is_aluimm = (instr_q[6:0] == OP_ALUIMM);
  assign is_alu    = is_alureg || is_aluimm;
  assign is_ebreak = (instr_q == INSTR_EBREAK);

  assign op_b  = is_alureg ? rs2 : {{20{instr_q[31]}}, instr_q[31:20]};
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = 32'd0;
    unique case (instr_q[14:12])
      F3_ADD:  alu_res = (is_alureg && instr_q[30]) ? (rs1 - op_b) : (rs1 + op_b);
      F3_SLL:  alu_res = rs1 << shamt;
      F3_SLT:  alu_res = {31'd0, $signed(rs1) < $signed(op_b)};
      F3_SLTU: alu_res = {31'd0, rs1 < op_b};
      F3_XOR:  alu_res = rs1 ^ op_b;
      F3_SR:   alu_res = instr_q[30] ? 32'($signed(rs1) >>> shamt) : (rs1 >> shamt);
      F3_OR:   alu_res = rs1 | op_b;
      F3_AND:  alu_res = rs1 & op_b;
      default: alu_res = 32'd0;
    endcase
  end

  // Write-back and unsupported pulses are live during EXECUTE; gating with
  // resetn abandons an instruction cleanly if reset lands in that cycle.
  assign in_exec     = resetn && (state_q == S_EXECUTE);
  assign wb_valid    = in_exec && is_alu && (instr_q[11:7] != 5'd0);
  assign unsupported = in_exec && !is_alu && !is_ebreak;
  assign instr_ready = resetn && (state_q == S_WAIT_INSTR);
  assign halted      = halted_q;

  // Report the live result during the pulse, then hold it until the next one.
  assign wb_rd   = wb_valid ? instr_q[11:7] : wb_rd_q;
  assign wb_data = wb_valid ? alu_res       : wb_data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_WAIT_INSTR;
      instr_q   <= 32'd0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      halted_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT_INSTR: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= S_READ_REGS;
          end
        end
        S_READ_REGS: state_q <= S_EXECUTE;
        S_EXECUTE: begin
          if (wb_valid) begin
            wb_rd_q   <= instr_q[11:7];
            wb_data_q <= alu_res;
          end
          if (is_ebreak && HALT_ON_EBREAK) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_WAIT_INSTR;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_WAIT_INSTR;
      endcase
    end
  end

endmodule
